// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- writeback stage placed directly in front of the register file.
//
// Holds a single MEM/WB entry, aligns and sign-extends load data, and
// produces a byte-granular write mask so that the partial-word loads LWL and
// LWR are merged by the register file itself (no read-modify-write of rt).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake (entry accepted when both high)
//   in_op               0 ALU, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR,
//                       8-15 reserved
//   in_addr_lo          load address bits [1:0]
//   in_rdata            word-aligned little-endian memory read data
//   in_alu              ALU result (op 0)
//   in_wen, in_dest     GPR write request and destination register
//   hold, flush         freeze the stage / discard its contents
//   reg_we, WR, WD      register file byte enables, register number, data
//   fwd_we/dest/data    forwarding copies of reg_we / WR / WD
//   retire_cnt          number of entries retired (wraps)
//   misalign            sticky: a misaligned LH/LHU/LW has been retired
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [1:0]       in_addr_lo,
  input  logic [31:0]      in_rdata,
  input  logic [31:0]      in_alu,
  input  logic             in_wen,
  input  logic [4:0]       in_dest,
  input  logic             hold,
  input  logic             flush,
  output logic [3:0]       reg_we,
  output logic [4:0]       WR,
  output logic [31:0]      WD,
  output logic [3:0]       fwd_we,
  output logic [4:0]       fwd_dest,
  output logic [31:0]      fwd_data,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             misalign
);

  typedef enum logic [3:0] {
    OP_ALU = 4'd0,
    OP_LB  = 4'd1,
    OP_LBU = 4'd2,
    OP_LH  = 4'd3,
    OP_LHU = 4'd4,
    OP_LW  = 4'd5,
    OP_LWL = 4'd6,
    OP_LWR = 4'd7
  } op_e;

  // Stage registers (one MEM/WB entry)
  logic        stage_valid;
  logic [3:0]  stage_op;
  logic [1:0]  stage_a;
  logic [31:0] stage_rdata;
  logic [31:0] stage_alu;
  logic        stage_wen;
  logic [4:0]  stage_dest;

  logic        accept;
  logic        retire;
  logic        misaligned;
  logic [3:0]  lane_we;
  logic [31:0] wd_c;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // flush always wins; a held full stage cannot take a new entry.
  assign in_ready = !flush && (!stage_valid || !hold);
  assign accept   = in_valid && in_ready;
  assign retire   = stage_valid && !hold && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_op    <= '0;
      stage_a     <= '0;
      stage_rdata <= '0;
      stage_alu   <= '0;
      stage_wen   <= 1'b0;
      stage_dest  <= '0;
      retire_cnt  <= '0;
      misalign    <= 1'b0;
    end else begin
      if (flush) begin
        stage_valid <= 1'b0;
      end else if (accept) begin
        stage_valid <= 1'b1;
        stage_op    <= in_op;
        stage_a     <= in_addr_lo;
        stage_rdata <= in_rdata;
        stage_alu   <= in_alu;
        stage_wen   <= in_wen;
        stage_dest  <= in_dest;
      end else if (retire) begin
        stage_valid <= 1'b0;
      end

      // Every retire counts, whether or not it writes a register.
      if (retire) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
        if (misaligned) misalign <= 1'b1;
      end
    end
  end

  assign sel_byte = stage_rdata[{stage_a, 3'b000} +: 8];
  assign sel_half = stage_a[1] ? stage_rdata[31:16] : stage_rdata[15:0];

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    wd_c       = '0;
    lane_we    = 4'b0000;
    misaligned = 1'b0;
    case (stage_op)
      OP_ALU: begin
        wd_c    = stage_alu;
        lane_we = 4'b1111;
      end
      OP_LB: begin
        wd_c    = {{24{sel_byte[7]}}, sel_byte};
        lane_we = 4'b1111;
      end
      OP_LBU: begin
        wd_c    = {24'h0, sel_byte};
        lane_we = 4'b1111;
      end
      OP_LH: begin
        wd_c       = {{16{sel_half[15]}}, sel_half};
        lane_we    = 4'b1111;
        misaligned = stage_a[0];
      end
      OP_LHU: begin
        wd_c       = {16'h0, sel_half};
        lane_we    = 4'b1111;
        misaligned = stage_a[0];
      end
      OP_LW: begin
        wd_c       = stage_rdata;
        lane_we    = 4'b1111;
        misaligned = (stage_a != 2'd0);
      end
      // LWL fills the upper bytes of rt: shift left, enable the top lanes.
      OP_LWL: begin
        wd_c    = stage_rdata << {2'd3 - stage_a, 3'b000};
        lane_we = 4'b1111 << (2'd3 - stage_a);
      end
      // LWR fills the lower bytes of rt: shift right, enable the low lanes.
      OP_LWR: begin
        wd_c    = stage_rdata >> {stage_a, 3'b000};
        lane_we = 4'b1111 >> stage_a;
      end
      default: begin
        // Reserved ops: no write, not flagged.
        wd_c    = '0;
        lane_we = 4'b0000;
      end
    endcase
  end

  // WR/WD always reflect the stage; only the enables are masked.
  assign reg_we = (stage_valid && !hold && !flush && stage_wen &&
                   (stage_dest != 5'd0) && !misaligned) ? lane_we : 4'b0000;
  assign WR     = stage_dest;
  assign WD     = wd_c;

  assign fwd_we   = reg_we;
  assign fwd_dest = WR;
  assign fwd_data = WD;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  localparam int CNT_W = 32;
  localparam int NVEC  = 21;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [1:0]       in_addr_lo;
  logic [31:0]      in_rdata;
  logic [31:0]      in_alu;
  logic             in_wen;
  logic [4:0]       in_dest;
  logic             hold;
  logic             flush;
  logic [3:0]       reg_we;
  logic [4:0]       WR;
  logic [31:0]      WD;
  logic [3:0]       fwd_we;
  logic [4:0]       fwd_dest;
  logic [31:0]      fwd_data;
  logic [CNT_W-1:0] retire_cnt;
  logic             misalign;

  wb_stage #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_addr_lo (in_addr_lo),
    .in_rdata   (in_rdata),
    .in_alu     (in_alu),
    .in_wen     (in_wen),
    .in_dest    (in_dest),
    .hold       (hold),
    .flush      (flush),
    .reg_we     (reg_we),
    .WR         (WR),
    .WD         (WD),
    .fwd_we     (fwd_we),
    .fwd_dest   (fwd_dest),
    .fwd_data   (fwd_data),
    .retire_cnt (retire_cnt),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] alu;
    logic        wen;
    logic [4:0]  dest;
    logic [3:0]  we;
    logic [31:0] wd;
    logic        chk_wd;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [3:0]  we;
    logic [4:0]  wr;
    logic [31:0] wd;
  } exp_t;

  vec_t vecs [NVEC];
  exp_t sb [$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] a,
                       input logic [31:0] d, input logic [31:0] alu,
                       input logic wen, input logic [4:0] dest);
    in_valid   = v;
    in_op      = op;
    in_addr_lo = a;
    in_rdata   = d;
    in_alu     = alu;
    in_wen     = wen;
    in_dest    = dest;
  endtask

  task automatic push(input logic [3:0] we, input logic [4:0] wr, input logic [31:0] wd);
    exp_t e;
    e.we = we;
    e.wr = wr;
    e.wd = wd;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: any register-file write seen mid-cycle (well clear of
  // both edges) must match the oldest outstanding expected write.
  always begin
    @(negedge clk);
    #2;
    if (reg_we !== 4'b0000) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_write", {28'h0, reg_we}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_we", {28'h0, reg_we}, {28'h0, e.we});
        check("sb_wr", {27'h0, WR}, {27'h0, e.wr});
        check("sb_wd", WD, e.wd);
        check("sb_fwd_data", fwd_data, e.wd);
      end
    end
  end

  initial begin
    logic exp_mis;

    //            op     a  d             alu           wen dest  we     wd            chk mis
    vecs[0]  = '{4'd5, 2'd0, 32'hDEADBEEF, 32'h0,        1'b1, 5'd5,  4'hF, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[1]  = '{4'd1, 2'd2, 32'h12805634, 32'h0,        1'b1, 5'd6,  4'hF, 32'hFFFFFF80, 1'b1, 1'b0};
    vecs[2]  = '{4'd2, 2'd2, 32'h12805634, 32'h0,        1'b1, 5'd6,  4'hF, 32'h00000080, 1'b1, 1'b0};
    vecs[3]  = '{4'd3, 2'd2, 32'h12805634, 32'h0,        1'b1, 5'd6,  4'hF, 32'h00001280, 1'b1, 1'b0};
    vecs[4]  = '{4'd3, 2'd0, 32'h00008001, 32'h0,        1'b1, 5'd10, 4'hF, 32'hFFFF8001, 1'b1, 1'b0};
    vecs[5]  = '{4'd4, 2'd0, 32'h00008001, 32'h0,        1'b1, 5'd10, 4'hF, 32'h00008001, 1'b1, 1'b0};
    vecs[6]  = '{4'd6, 2'd1, 32'hAABBCCDD, 32'h0,        1'b1, 5'd11, 4'hC, 32'hCCDD0000, 1'b1, 1'b0};
    vecs[7]  = '{4'd7, 2'd1, 32'hAABBCCDD, 32'h0,        1'b1, 5'd11, 4'h7, 32'h00AABBCC, 1'b1, 1'b0};
    vecs[8]  = '{4'd6, 2'd0, 32'hAABBCCDD, 32'h0,        1'b1, 5'd12, 4'h8, 32'hDD000000, 1'b1, 1'b0};
    vecs[9]  = '{4'd7, 2'd3, 32'hAABBCCDD, 32'h0,        1'b1, 5'd12, 4'h1, 32'h000000AA, 1'b1, 1'b0};
    vecs[10] = '{4'd5, 2'd2, 32'h11223344, 32'h0,        1'b1, 5'd7,  4'h0, 32'h11223344, 1'b1, 1'b1};
    vecs[11] = '{4'd0, 2'd0, 32'h0,        32'h12345678, 1'b1, 5'd0,  4'h0, 32'h12345678, 1'b1, 1'b0};
    vecs[12] = '{4'd0, 2'd0, 32'h0,        32'hCAFEF00D, 1'b0, 5'd3,  4'h0, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[13] = '{4'd9, 2'd0, 32'h55555555, 32'h66666666, 1'b1, 5'd4,  4'h0, 32'h0,        1'b0, 1'b0};
    vecs[14] = '{4'd1, 2'd3, 32'h7F000000, 32'h0,        1'b1, 5'd8,  4'hF, 32'h0000007F, 1'b1, 1'b0};
    vecs[15] = '{4'd4, 2'd3, 32'h00000000, 32'h0,        1'b1, 5'd2,  4'h0, 32'h00000000, 1'b1, 1'b1};
    vecs[16] = '{4'd7, 2'd0, 32'h89ABCDEF, 32'h0,        1'b1, 5'd31, 4'hF, 32'h89ABCDEF, 1'b1, 1'b0};
    vecs[17] = '{4'd6, 2'd3, 32'h89ABCDEF, 32'h0,        1'b1, 5'd31, 4'hF, 32'h89ABCDEF, 1'b1, 1'b0};
    vecs[18] = '{4'd6, 2'd2, 32'h89ABCDEF, 32'h0,        1'b1, 5'd30, 4'hE, 32'hABCDEF00, 1'b1, 1'b0};
    vecs[19] = '{4'd7, 2'd2, 32'h89ABCDEF, 32'h0,        1'b1, 5'd30, 4'h3, 32'h000089AB, 1'b1, 1'b0};
    vecs[20] = '{4'd3, 2'd1, 32'h00000000, 32'h0,        1'b1, 5'd1,  4'h0, 32'h00000000, 1'b1, 1'b1};

    rst   = 1'b1;
    hold  = 1'b0;
    flush = 1'b0;
    drive(1'b0, 4'd0, 2'd0, 32'h0, 32'h0, 1'b0, 5'd0);

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_in_ready",   {31'h0, in_ready}, 32'h1);
    check("rst_reg_we",     {28'h0, reg_we},   32'h0);
    check("rst_wr",         {27'h0, WR},       32'h0);
    check("rst_wd",         WD,                32'h0);
    check("rst_retire_cnt", retire_cnt,        32'h0);
    check("rst_misalign",   {31'h0, misalign}, 32'h0);
    rst = 1'b0;

    // ---------------- table: back-to-back entries ----------------
    exp_mis = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].d, vecs[i].alu, vecs[i].wen, vecs[i].dest);
      if (vecs[i].we != 4'h0) push(vecs[i].we, vecs[i].dest, vecs[i].wd);
      @(posedge clk);
      #1;
      if (i > 0 && vecs[i-1].mis) exp_mis = 1'b1;
      check($sformatf("vec%0d_reg_we", i), {28'h0, reg_we}, {28'h0, vecs[i].we});
      check($sformatf("vec%0d_fwd_we", i), {28'h0, fwd_we}, {28'h0, vecs[i].we});
      if (vecs[i].chk_wd) check($sformatf("vec%0d_wd", i), WD, vecs[i].wd);
      check($sformatf("vec%0d_retire_cnt", i), retire_cnt, i);
      check($sformatf("vec%0d_misalign", i), {31'h0, misalign}, {31'h0, exp_mis});
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    if (vecs[NVEC-1].mis) exp_mis = 1'b1;
    check("table_retire_cnt", retire_cnt, NVEC);
    check("table_misalign",   {31'h0, misalign}, {31'h0, exp_mis});
    check("table_drained",    {31'h0, in_ready}, 32'h1);

    // ---------------- hold in a back-to-back ALU stream ----------------
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("hold_cnt_cleared", retire_cnt, 32'h0);
    drive(1'b1, 4'd0, 2'd0, 32'h0, 32'h00000100, 1'b1, 5'd1);
    push(4'hF, 5'd1, 32'h00000100);
    @(negedge clk);
    drive(1'b1, 4'd0, 2'd0, 32'h0, 32'h00000101, 1'b1, 5'd2);
    push(4'hF, 5'd2, 32'h00000101);
    @(negedge clk);
    drive(1'b1, 4'd0, 2'd0, 32'h0, 32'h00000102, 1'b1, 5'd3);
    push(4'hF, 5'd3, 32'h00000102);
    hold = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("hold%0d_in_ready", c), {31'h0, in_ready}, 32'h0);
      check($sformatf("hold%0d_reg_we", c),   {28'h0, reg_we},   32'h0);
      check($sformatf("hold%0d_wr", c),       {27'h0, WR},       32'h2);
      if (c == 0) @(negedge clk);
    end
    @(negedge clk);
    hold = 1'b0;
    @(negedge clk);
    drive(1'b1, 4'd0, 2'd0, 32'h0, 32'h00000103, 1'b1, 5'd4);
    push(4'hF, 5'd4, 32'h00000103);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_retire_cnt", retire_cnt, 32'd4);
    check("hold_sb_empty", sb.size(), 32'd0);

    // ---------------- flush while held with in_valid ----------------
    drive(1'b1, 4'd0, 2'd0, 32'h0, 32'h0000AAAA, 1'b1, 5'd9);
    @(negedge clk);
    hold = 1'b1;
    drive(1'b1, 4'd0, 2'd0, 32'h0, 32'h0000BBBB, 1'b1, 5'd10);
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_in_ready", {31'h0, in_ready}, 32'h0);
    check("flush_reg_we",   {28'h0, reg_we},   32'h0);
    @(negedge clk);
    flush = 1'b0;
    hold  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_empty_reg_we", {28'h0, reg_we}, 32'h0);
    check("flush_empty_ready",  {31'h0, in_ready}, 32'h1);
    check("flush_cnt",          retire_cnt, 32'd4);
    @(negedge clk);
    check("flush_cnt_later", retire_cnt, 32'd4);

    // ---------------- asynchronous reset mid-stream ----------------
    drive(1'b1, 4'd5, 2'd0, 32'h55AA55AA, 32'h0, 1'b1, 5'd3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pre_rst_wd", WD, 32'h55AA55AA);
    #1;
    rst = 1'b1;
    #1;
    check("arst_reg_we",     {28'h0, reg_we},   32'h0);
    check("arst_wr",         {27'h0, WR},       32'h0);
    check("arst_wd",         WD,                32'h0);
    check("arst_retire_cnt", retire_cnt,        32'h0);
    check("arst_misalign",   {31'h0, misalign}, 32'h0);
    check("arst_in_ready",   {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    check("final_sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage sitting directly upstream of the register file.
- Holds one MEM/WB pipeline entry and aligns and sign-extends load data.
- Produces the register file's byte write mask `reg_we[3:0]`, the destination `WR` and the write data `WD`.
- Byte-granular `reg_we` carries the partial writes of LWL/LWR, so no read-modify-write of rt is needed.
- Also drives forwarding outputs, a retired-instruction counter and a sticky misalign flag.

Parameters:
- CNT_W, 32, width of the retire counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_op  in  4  0 ALU, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR, 8-15 reserved
- in_addr_lo  in  2  load address bits [1:0]
- in_rdata  in  32  word-aligned memory read data, little-endian
- in_alu  in  32  result for op 0
- in_wen  in  1  instruction writes a GPR
- in_dest  in  5  destination register
- hold  in  1  freeze stage (debug/stall)
- flush  in  1  kill stage contents
- reg_we  out  4  byte write enables to the register file
- WR  out  5  write register number
- WD  out  32  write data, bytes placed in final lane positions
- fwd_we  out  4  equals reg_we; a consumer merges per byte
- fwd_dest  out  5  equals WR
- fwd_data  out  32  equals WD
- retire_cnt  out  CNT_W  count of retired entries
- misalign  out  1  sticky: a misaligned LH/LHU/LW was retired

Behaviour:
- Reset (asynchronous, `rst`=1):
  - stage_valid=0; all stage registers 0.
  - reg_we=0, WR=0, WD=0, retire_cnt=0, misalign=0.
  - `in_ready` follows its equation, so it reads 1.
- Handshake:
  - in_ready = !flush && (!stage_valid || !hold).
  - An entry is accepted at posedge when in_valid && in_ready. Its fields are registered, and stage_valid is set to 1.
  - If stage_valid && !hold && !flush and nothing is accepted, stage_valid goes to 0 at the edge.
- Outputs are combinational from stage registers only (no input-to-output path except the masking below).
  - An entry accepted at edge N drives reg_we/WR/WD during cycle N to N+1.
  - The register file writes it at edge N+1.
- Output masking: reg_we=0 when !stage_valid || hold || flush || !stage_wen || stage_dest==0 || error. WR and WD still reflect the stage contents.
- Alignment (a = addr_lo, d = rdata):
  - ALU: WD=alu, we=1111.
  - LB/LBU: byte d[8a+7:8a], sign- or zero-extended; we=1111.
  - LH/LHU: a[0] must be 0; half = a[1] ? d[31:16] : d[15:0]; sign- or zero-extended; we=1111.
  - LW: a must be 0; WD=d; we=1111.
  - LWL: WD = d << 8*(3-a); we by a = 0:1000, 1:1100, 2:1110, 3:1111.
  - LWR: WD = d >> 8*a; we by a = 0:1111, 1:0111, 2:0011, 3:0001.
  - Vacated bits of the shifted WD are 0.
- Error conditions:
  - LH/LHU with a[0]=1, or LW with a!=0, is misaligned; it counts as error with reg_we=0.
  - Reserved op: reg_we=0; not flagged.
- Retire: an entry retires on an edge when stage_valid && !hold && !flush.
  - retire_cnt increments by 1 per retire, regardless of wen or error, and wraps modulo 2^CNT_W.
  - On retire of a misaligned entry, misalign is set to 1; it clears only on reset.
- Simultaneous events:
  - flush beats accept and retire: the stage empties and nothing is counted.
  - hold with stage full: contents unchanged, no count, in_ready=0.
  - Accept while retiring: back-to-back, full throughput of 1 per cycle.
- Reset mid-operation: all state clears immediately; any entry being held is discarded, with no write.

Test Plan:
- After reset, LW a=0, rdata=0xDEADBEEF, dest=5 → next cycle reg_we=1111, WR=5, WD=0xDEADBEEF, then retire_cnt=1.
- LB a=2, rdata=0x12805634 → WD=0xFFFFFF80. Same input as LBU → WD=0x00000080. LH a=2 → WD=0x00001280.
- LWL a=1, rdata=0xAABBCCDD → reg_we=1100, WD=0xCCDD0000. LWR a=1, same data → reg_we=0111, WD=0x00AABBCC.
- LW a=2 → reg_we=0, misalign=1 and stays 1 after later valid loads; retire_cnt still increments. ALU with dest=0 → reg_we=0.
- Four back-to-back ALU entries with hold=1 for 2 cycles on the second → in_ready=0 and reg_we=0 during hold, no entry lost or duplicated, retire_cnt=4.
- Assert flush while an entry is held and in_valid=1 → next cycle stage empty, reg_we=0, count unchanged. Assert rst mid-stream → all outputs 0 asynchronously.
